// File: rtl/sub_bytes_seq_if.sv
// Handshake bundle for the sequential SubBytes engine: input block port and output block port.
// Latency: none (signal bundle only).
// Backpressure: carries inValid/inReady and outValid/outReady; the master drives inputs, the slave is the engine.
//
// Signals:
//   inValid  : inState holds a valid block (master -> slave)
//   inReady  : engine can accept a block (slave -> master)
//   inState  : 128-bit state, byte 0 in bits [127:120] (master -> slave)
//   outValid : outState holds a completed block (slave -> master)
//   outReady : downstream accepts the block (master -> slave)
//   outState : 128-bit substituted state, same byte order (slave -> master)
interface sub_bytes_seq_if;
    logic         inValid;
    logic         inReady;
    logic [127:0] inState;
    logic         outValid;
    logic         outReady;
    logic [127:0] outState;

    modport master (
        output inValid, inState, outReady,
        input  inReady, outValid, outState
    );

    modport slave (
        input  inValid, inState, outReady,
        output inReady, outValid, outState
    );
endinterface

// File: rtl/sub_bytes_seq.sv
// Sequential forward AES SubBytes: substitutes BYTES_PER_CYCLE bytes per clock through shared S-boxes.
// Latency: outValid rises N = 16/BYTES_PER_CYCLE edges after the accept edge; one block per N+2 cycles.
// Backpressure: holds the finished block in DONE until outReady; no new block is taken until back in IDLE.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (discards any in-flight block)
//   bus   : slave side of sub_bytes_seq_if (inValid/inReady/inState, outValid/outReady/outState)
//   busy  : high whenever the engine is not in IDLE
module sub_bytes_seq #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    sub_bytes_seq_if.slave  bus,
    output logic            busy
);

    localparam int N  = 16 / BYTES_PER_CYCLE;
    localparam int W  = 8 * BYTES_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
              BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_param
            $error("sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SUB  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Forward S-box, entry 0 leftmost so SBOX[x] is the substitution of x.
    localparam logic [0:255][7:0] SBOX = {
        256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
        256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
        256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
        256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
        256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
        256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
        256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
        256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
    };

    logic [1:0]    r_fsm;
    logic [CW-1:0] r_cnt;
    logic [127:0]  r_state;

    logic [W-1:0]  w_chunk;
    logic [W-1:0]  w_sub;
    logic [127:0]  w_next;

    // Select the chunk addressed by the counter; chunk 0 is the most significant bytes.
    always_comb begin
        w_chunk = '0;
        for (int c = 0; c < N; c++) begin
            if (r_cnt == CW'(c)) begin
                w_chunk = r_state[127 - c*W -: W];
            end
        end
    end

    // Shared S-box lanes, one per byte of the chunk.
    genvar b;
    generate
        for (b = 0; b < BYTES_PER_CYCLE; b++) begin : g_lane
            assign w_sub[W-1-8*b -: 8] = SBOX[w_chunk[W-1-8*b -: 8]];
        end
    endgenerate

    // In-place write-back of the substituted chunk.
    always_comb begin
        w_next = r_state;
        for (int c = 0; c < N; c++) begin
            if (r_cnt == CW'(c)) begin
                w_next[127 - c*W -: W] = w_sub;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm   <= ST_IDLE;
            r_cnt   <= '0;
            r_state <= '0;
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    if (bus.inValid) begin
                        r_state <= bus.inState;
                        r_cnt   <= '0;
                        r_fsm   <= ST_SUB;
                    end
                end
                ST_SUB: begin
                    r_state <= w_next;
                    if (r_cnt == CW'(N - 1)) begin
                        r_cnt <= '0;
                        r_fsm <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    // Release only; a new block is taken from IDLE on a later edge.
                    if (bus.outReady) begin
                        r_fsm <= ST_IDLE;
                    end
                end
                default: r_fsm <= ST_IDLE;
            endcase
        end
    end

    assign bus.inReady  = (r_fsm == ST_IDLE);
    assign bus.outValid = (r_fsm == ST_DONE);
    assign bus.outState = r_state;
    assign busy         = (r_fsm != ST_IDLE);

endmodule

// File: tb/tb_sub_bytes_seq.sv
module tb_sub_bytes_seq;

    logic clk;
    logic rst_n;
    logic busy4, busy1, busy2, busy8, busy16;

    int checks;
    int failures;

    sub_bytes_seq_if bus4();
    sub_bytes_seq_if bus1();
    sub_bytes_seq_if bus2();
    sub_bytes_seq_if bus8();
    sub_bytes_seq_if bus16();

    sub_bytes_seq #(.BYTES_PER_CYCLE(4))  dut   (.clk(clk), .rst_n(rst_n), .bus(bus4),  .busy(busy4));
    sub_bytes_seq #(.BYTES_PER_CYCLE(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1),  .busy(busy1));
    sub_bytes_seq #(.BYTES_PER_CYCLE(2))  dut2  (.clk(clk), .rst_n(rst_n), .bus(bus2),  .busy(busy2));
    sub_bytes_seq #(.BYTES_PER_CYCLE(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8),  .busy(busy8));
    sub_bytes_seq #(.BYTES_PER_CYCLE(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16), .busy(busy16));

    // The four other widths are driven in lockstep from shared inputs.
    logic         x_valid;
    logic         x_ready;
    logic [127:0] x_state;
    logic         x_ov [4];
    logic [127:0] x_os [4];

    assign bus1.inValid  = x_valid;  assign bus1.inState  = x_state;  assign bus1.outReady  = x_ready;
    assign bus2.inValid  = x_valid;  assign bus2.inState  = x_state;  assign bus2.outReady  = x_ready;
    assign bus8.inValid  = x_valid;  assign bus8.inState  = x_state;  assign bus8.outReady  = x_ready;
    assign bus16.inValid = x_valid;  assign bus16.inState = x_state;  assign bus16.outReady = x_ready;
    assign x_ov[0] = bus1.outValid;  assign x_os[0] = bus1.outState;
    assign x_ov[1] = bus2.outValid;  assign x_os[1] = bus2.outState;
    assign x_ov[2] = bus8.outValid;  assign x_os[2] = bus8.outState;
    assign x_ov[3] = bus16.outValid; assign x_os[3] = bus16.outState;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference S-box derived from GF(2^8) inversion plus the AES affine map.
    logic [7:0] sb [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic build_model();
        logic [7:0] inv;
        logic [7:0] v;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            v = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sb[x] = v;
        end
    endtask

    function automatic logic [127:0] ref_sub(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = sb[s[127 - 8*i -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one block into the B=4 engine with outReady high; report latency, result, and
    // whether outValid was still high one cycle after it first appeared.
    task automatic do_block(input logic [127:0] s, output int lat, output logic [127:0] res,
                            output logic stay);
        int n;
        lat  = -1;
        res  = '0;
        stay = 1'b0;
        bus4.outReady = 1'b1;
        bus4.inState  = s;
        bus4.inValid  = 1'b1;
        n = 0;
        while (!bus4.inReady && n < 50) begin
            tick();
            n++;
        end
        tick();
        bus4.inValid = 1'b0;
        bus4.inState = rand128();
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (bus4.outValid) begin
                lat = i;
                res = bus4.outState;
                break;
            end
        end
        if (lat > 0) begin
            tick();
            stay = bus4.outValid;
        end
    endtask

    task automatic test_reset();
        int lat;
        logic [127:0] res;
        logic stay;
        rst_n = 1'b0;
        #3;
        checks++;
        if (bus4.inReady !== 1'b1 || bus4.outValid !== 1'b0 || busy4 !== 1'b0 || bus4.outState !== 128'h0) begin
            failures++;
            $display("FAIL reset_idle: inReady=%b outValid=%b busy=%b outState=%h required 1 0 0 0",
                     bus4.inReady, bus4.outValid, busy4, bus4.outState);
        end
        tick();
        rst_n = 1'b1;
        tick();
        // Start a block, abort it mid-SUB with an asynchronous reset.
        bus4.outReady = 1'b1;
        bus4.inState  = rand128() | 128'h1;
        bus4.inValid  = 1'b1;
        tick();
        bus4.inValid = 1'b0;
        tick();
        checks++;
        if (busy4 !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre_busy: busy=%b required 1", busy4);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus4.inReady !== 1'b1 || bus4.outValid !== 1'b0 || busy4 !== 1'b0 || bus4.outState !== 128'h0) begin
            failures++;
            $display("FAIL reset_async: inReady=%b outValid=%b busy=%b outState=%h required 1 0 0 0",
                     bus4.inReady, bus4.outValid, busy4, bus4.outState);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        do_block(128'h193de3bea0f4e22b9ac68d2ae9f84808, lat, res, stay);
        checks++;
        if (res !== 128'hd42711aee0bf98f1b8b45de51e415230 || lat != 4) begin
            failures++;
            $display("FAIL reset_then_fips: outState=%h lat=%0d required d42711aee0bf98f1b8b45de51e415230 lat=4",
                     res, lat);
        end
    endtask

    task automatic test_fips();
        int lat;
        logic [127:0] res;
        logic stay;
        do_block(128'h193de3bea0f4e22b9ac68d2ae9f84808, lat, res, stay);
        checks++;
        if (res !== 128'hd42711aee0bf98f1b8b45de51e415230) begin
            failures++;
            $display("FAIL fips_result: got %h required d42711aee0bf98f1b8b45de51e415230", res);
        end
        checks++;
        if (lat != 4) begin
            failures++;
            $display("FAIL fips_latency: got %0d required 4", lat);
        end
        checks++;
        if (stay !== 1'b0 || bus4.inReady !== 1'b1) begin
            failures++;
            $display("FAIL fips_one_cycle: outValid after=%b inReady=%b required 0 1", stay, bus4.inReady);
        end
    endtask

    task automatic test_byte_order();
        logic [127:0] vec [2];
        logic [127:0] exp_v [2];
        int lat [4];
        logic [127:0] res [4];
        int want_n [4];
        int l4;
        logic [127:0] r4;
        logic stay;
        vec[0] = 128'h000102030405060708090a0b0c0d0e0f;
        vec[1] = {16{8'hff}};
        exp_v[0] = 128'h637c777bf26b6fc53001672bfed7ab76;
        exp_v[1] = {16{8'h16}};
        want_n[0] = 16; want_n[1] = 8; want_n[2] = 2; want_n[3] = 1;
        for (int v = 0; v < 2; v++) begin
            do_block(vec[v], l4, r4, stay);
            checks++;
            if (r4 !== exp_v[v] || l4 != 4) begin
                failures++;
                $display("FAIL order_b4_%0d: got %h lat=%0d required %h lat=4", v, r4, l4, exp_v[v]);
            end
            for (int j = 0; j < 4; j++) begin
                lat[j] = -1;
                res[j] = '0;
            end
            x_ready = 1'b1;
            x_state = vec[v];
            x_valid = 1'b1;
            tick();
            x_valid = 1'b0;
            x_state = rand128();
            for (int t = 1; t <= 20; t++) begin
                tick();
                for (int j = 0; j < 4; j++) begin
                    if (lat[j] < 0 && x_ov[j]) begin
                        lat[j] = t;
                        res[j] = x_os[j];
                    end
                end
            end
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (res[j] !== exp_v[v] || lat[j] != want_n[j]) begin
                    failures++;
                    $display("FAIL order_n%0d_%0d: got %h lat=%0d required %h lat=%0d",
                             want_n[j], v, res[j], lat[j], exp_v[v], want_n[j]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] s;
        logic [127:0] held;
        int n;
        int bad;
        int lat;
        logic [127:0] res;
        logic stay;
        s = rand128();
        bus4.outReady = 1'b0;
        bus4.inState  = s;
        bus4.inValid  = 1'b1;
        tick();
        bus4.inValid = 1'b0;
        n = 0;
        while (!bus4.outValid && n < 50) begin
            tick();
            n++;
        end
        held = bus4.outState;
        checks++;
        if (bus4.outValid !== 1'b1 || held !== ref_sub(s)) begin
            failures++;
            $display("FAIL bp_result: outValid=%b outState=%h required 1 %h", bus4.outValid, held, ref_sub(s));
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            bus4.inValid = i[0];
            bus4.inState = rand128();
            tick();
            if (bus4.outValid !== 1'b1 || bus4.outState !== held || bus4.inReady !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL bp_hold: %0d unstable cycles required 0", bad);
        end
        bus4.inValid  = 1'b0;
        bus4.outReady = 1'b1;
        tick();
        checks++;
        if (bus4.outValid !== 1'b0 || bus4.inReady !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: outValid=%b inReady=%b required 0 1", bus4.outValid, bus4.inReady);
        end
        s = rand128();
        do_block(s, lat, res, stay);
        checks++;
        if (res !== ref_sub(s) || lat != 4) begin
            failures++;
            $display("FAIL bp_next: got %h lat=%0d required %h lat=4", res, lat, ref_sub(s));
        end
    endtask

    task automatic test_inverse();
        int lat;
        logic [127:0] res;
        logic stay;
        do_block({16{8'h52}}, lat, res, stay);
        checks++;
        if (res !== 128'h0) begin
            failures++;
            $display("FAIL inverse_52: got %h required 0", res);
        end
    endtask

    task automatic test_throughput();
        int acc [$];
        int n;
        bus4.outReady = 1'b1;
        bus4.inValid  = 1'b1;
        for (int t = 0; t < 40; t++) begin
            bus4.inState = rand128();
            if (bus4.inReady) acc.push_back(t);
            tick();
        end
        bus4.inValid = 1'b0;
        n = 0;
        while (busy4 && n < 50) begin
            tick();
            n++;
        end
        for (int i = 1; i < 5; i++) begin
            checks++;
            if (acc.size() <= i) begin
                failures++;
                $display("FAIL throughput_%0d: only %0d accepts required at least %0d", i, acc.size(), i + 1);
            end else if (acc[i] - acc[i-1] != 6) begin
                failures++;
                $display("FAIL throughput_%0d: spacing %0d required 6", i, acc[i] - acc[i-1]);
            end
        end
    endtask

    task automatic test_random_stream();
        logic [127:0] q [$];
        logic [127:0] e;
        int sent;
        int delivered;
        int cyc;
        sent = 0;
        delivered = 0;
        cyc = 0;
        while (delivered < 1000 && cyc < 30000) begin
            bus4.inValid  = (sent < 1000) && ($urandom_range(3) != 0);
            bus4.inState  = rand128();
            bus4.outReady = ($urandom_range(3) != 0);
            if (bus4.outValid && bus4.outReady) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL stream_dup: block delivered with none outstanding, outState=%h", bus4.outState);
                end else begin
                    e = q.pop_front();
                    if (bus4.outState !== e) begin
                        failures++;
                        $display("FAIL stream_data: block %0d got %h required %h", delivered, bus4.outState, e);
                    end
                end
                delivered++;
            end
            if (bus4.inValid && bus4.inReady) begin
                q.push_back(ref_sub(bus4.inState));
                sent++;
            end
            tick();
            cyc++;
        end
        bus4.inValid  = 1'b0;
        bus4.outReady = 1'b1;
        checks++;
        if (delivered != 1000 || sent != 1000 || q.size() != 0) begin
            failures++;
            $display("FAIL stream_count: sent=%0d delivered=%0d pending=%0d required 1000 1000 0",
                     sent, delivered, q.size());
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        bus4.inValid  = 1'b0;
        bus4.inState  = '0;
        bus4.outReady = 1'b1;
        x_valid = 1'b0;
        x_ready = 1'b1;
        x_state = '0;
        build_model();
        test_reset();
        test_fips();
        test_byte_order();
        test_backpressure();
        test_inverse();
        test_throughput();
        test_random_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
